// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - operand/result handshake bundle for alu_mc
interface alu_mc_if #(
   parameter int WIDTH  = 16,
   parameter int CTRL_W = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] ctrl;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  y;
   logic [WIDTH-1:0]  y_hi;
   logic [4:0]        flags;

   modport master (
      output in_valid, ctrl, a, b, out_ready,
      input  in_ready, out_valid, y, y_hi, flags
   );

   modport slave (
      input  in_valid, ctrl, a, b, out_ready,
      output in_ready, out_valid, y, y_hi, flags
   );
endinterface

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with iterative multiply/divide and a one-entry result register
module alu_mc #(
   parameter int WIDTH  = 16,
   parameter int CTRL_W = 4
) (
   input logic     clk,
   input logic     reset,
   alu_mc_if.slave bus
);
   localparam int SW = $clog2(WIDTH);

   localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(0);
   localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(1);
   localparam logic [CTRL_W-1:0] OP_MUL = CTRL_W'(2);
   localparam logic [CTRL_W-1:0] OP_NEG = CTRL_W'(3);
   localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(4);
   localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(5);
   localparam logic [CTRL_W-1:0] OP_XOR = CTRL_W'(6);
   localparam logic [CTRL_W-1:0] OP_SHL = CTRL_W'(7);
   localparam logic [CTRL_W-1:0] OP_SHR = CTRL_W'(8);
   localparam logic [CTRL_W-1:0] OP_SRA = CTRL_W'(9);
   localparam logic [CTRL_W-1:0] OP_DIV = CTRL_W'(10);
   localparam logic [CTRL_W-1:0] OP_MOD = CTRL_W'(11);

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t           state;
   logic [SW-1:0]    cnt;
   logic [WIDTH-1:0] opd;     // multiplicand or divisor
   logic [WIDTH-1:0] acc_hi;  // running high product or partial remainder
   logic [WIDTH-1:0] acc_lo;  // multiplier bits or dividend/quotient bits
   logic             is_mod;

   logic             out_valid_q;
   logic [WIDTH-1:0] y_q;
   logic [WIDTH-1:0] y_hi_q;
   logic [4:0]       flags_q;

   logic             accept;

   assign bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign bus.y_hi      = y_hi_q;
   assign bus.flags     = flags_q;

   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_hi;
   logic             r_c;
   logic             r_v;
   logic             r_dz;
   logic             iterative;
   logic [WIDTH:0]   ext;
   logic [SW-1:0]    sh;

   always_comb begin
      r_y       = '0;
      r_hi      = '0;
      r_c       = 1'b0;
      r_v       = 1'b0;
      r_dz      = 1'b0;
      iterative = 1'b0;
      ext       = '0;
      sh        = bus.b[SW-1:0];
      case (bus.ctrl)
         OP_ADD: begin
            ext = {1'b0, bus.a} + {1'b0, bus.b};
            r_y = ext[WIDTH-1:0];
            r_c = ext[WIDTH];
            r_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (r_y[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            ext = {1'b0, bus.a} - {1'b0, bus.b};
            r_y = ext[WIDTH-1:0];
            r_c = ext[WIDTH];
            r_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (r_y[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_NEG: begin
            r_y = '0 - bus.a;
            r_c = |bus.a;
            r_v = (bus.a == MIN_NEG);
         end
         OP_AND: r_y = bus.a & bus.b;
         OP_OR:  r_y = bus.a | bus.b;
         OP_XOR: r_y = bus.a ^ bus.b;
         // The extra bit of ext catches the last bit shifted out.
         OP_SHL: begin
            ext = {1'b0, bus.a} << sh;
            r_y = ext[WIDTH-1:0];
            r_c = ext[WIDTH];
         end
         OP_SHR: begin
            ext = {bus.a, 1'b0} >> sh;
            r_y = ext[WIDTH:1];
            r_c = ext[0];
         end
         OP_SRA: begin
            ext = $unsigned($signed({bus.a, 1'b0}) >>> sh);
            r_y = ext[WIDTH:1];
            r_c = ext[0];
         end
         OP_MUL: iterative = 1'b1;
         OP_DIV, OP_MOD: begin
            if (bus.b == '0) begin
               r_y  = '1;
               r_hi = bus.a;
               r_dz = 1'b1;
            end else begin
               iterative = 1'b1;
            end
         end
         default: ;
      endcase
   end

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;
   logic [WIDTH-1:0] fin_y;
   logic [WIDTH-1:0] fin_hi;
   logic             fin_cv;

   always_comb begin
      mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
      shifted = {acc_hi, acc_lo[WIDTH-1]};
      trial   = shifted - {1'b0, opd};
      if (state == MUL) begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
         step_hi = trial[WIDTH-1:0];
         step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
         step_hi = shifted[WIDTH-1:0];
         step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
      fin_y  = step_lo;
      fin_hi = step_hi;
      fin_cv = 1'b0;
      if (state == MUL) begin
         fin_cv = |step_hi;
      end else if (is_mod) begin
         fin_y  = step_hi;
         fin_hi = step_lo;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         opd         <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         is_mod      <= 1'b0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         y_hi_q      <= '0;
         flags_q     <= '0;
      end else begin
         if (bus.out_ready) out_valid_q <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               if (iterative) begin
                  state  <= (bus.ctrl == OP_MUL) ? MUL : DIV;
                  cnt    <= '0;
                  opd    <= (bus.ctrl == OP_MUL) ? bus.a : bus.b;
                  acc_lo <= (bus.ctrl == OP_MUL) ? bus.b : bus.a;
                  acc_hi <= '0;
                  is_mod <= (bus.ctrl == OP_MOD);
               end else begin
                  out_valid_q <= 1'b1;
                  y_q         <= r_y;
                  y_hi_q      <= r_hi;
                  flags_q     <= {r_dz, r_v, r_c, r_y[WIDTH-1], ~|r_y};
               end
            end
            MUL, DIV: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt + 1'b1;
               if (cnt == SW'(WIDTH-1)) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b1;
                  y_q         <= fin_y;
                  y_hi_q      <= fin_hi;
                  flags_q     <= {1'b0, fin_cv, fin_cv, fin_y[WIDTH-1], ~|fin_y};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc
module tb_alu_mc;
   localparam int W = 16;
   localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL = 4'd2,  OP_NEG = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_SHL = 4'd7;
   localparam logic [3:0] OP_SHR = 4'd8,  OP_SRA = 4'd9,  OP_DIV = 4'd10, OP_MOD = 4'd11;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   alu_mc_if #(.WIDTH(W), .CTRL_W(4)) bus ();
   alu_mc #(.WIDTH(W), .CTRL_W(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [W-1:0] y;
      logic [W-1:0] hi;
      logic [4:0]   f;
      int           lat;
      int           acc;
      bit           seen;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference behaviour from plain integer arithmetic.
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] w);
      exp_t        e;
      int          sx, sw, r, n;
      logic [31:0] p;
      logic        c, v, dz;
      c = 1'b0; v = 1'b0; dz = 1'b0;
      e.y = '0; e.hi = '0; e.lat = 1; e.acc = cyc; e.seen = 1'b0;
      sx = int'($signed(x));
      sw = int'($signed(w));
      n  = int'(w[3:0]);
      case (op)
         OP_ADD: begin
            r = int'(x) + int'(w);
            e.y = 16'(r);
            c = (r > 65535);
            v = (sx + sw > 32767) || (sx + sw < -32768);
         end
         OP_SUB: begin
            e.y = x - w;
            c = (x < w);
            v = (sx - sw > 32767) || (sx - sw < -32768);
         end
         OP_MUL: begin
            p = 32'(x) * 32'(w);
            e.y = p[15:0];
            e.hi = p[31:16];
            c = (e.hi != 0);
            v = c;
            e.lat = W + 1;
         end
         OP_NEG: begin
            e.y = -x;
            c = (x != 0);
            v = (-sx > 32767);
         end
         OP_AND: e.y = x & w;
         OP_OR:  e.y = x | w;
         OP_XOR: e.y = x ^ w;
         OP_SHL: begin
            e.y = x << n;
            c = (n != 0) ? x[16-n] : 1'b0;
         end
         OP_SHR: begin
            e.y = x >> n;
            c = (n != 0) ? x[n-1] : 1'b0;
         end
         OP_SRA: begin
            e.y = 16'(sx >>> n);
            c = (n != 0) ? x[n-1] : 1'b0;
         end
         OP_DIV, OP_MOD: begin
            if (w == 0) begin
               e.y = 16'hFFFF;
               e.hi = x;
               dz = 1'b1;
            end else begin
               e.y  = (op == OP_DIV) ? x / w : x % w;
               e.hi = (op == OP_DIV) ? x % w : x / w;
               e.lat = W + 1;
            end
         end
         default: ;
      endcase
      e.f = {dz, v, c, e.y[15], (e.y == 0)};
      return e;
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         q.delete();
      end else begin
         if (bus.out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out_valid", bus.out_valid, 1'b0);
            end else begin
               if (!q[0].seen) begin
                  chk("latency", cyc - q[0].acc, q[0].lat);
                  q[0].seen = 1'b1;
               end
               chk("mon_y", bus.y, q[0].y);
               chk("mon_y_hi", bus.y_hi, q[0].hi);
               chk("mon_flags", bus.flags, q[0].f);
               if (bus.out_ready) void'(q.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready) q.push_back(model(bus.ctrl, bus.a, bus.b));
      end
   end

   // Call at posedge+1; returns at posedge+1 after the accept edge.
   task automatic send(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] w);
      bus.in_valid = 1'b1;
      bus.ctrl = op;
      bus.a = x;
      bus.b = w;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (bus.in_ready) break;
      end
      chk("send_accept", bus.in_ready, 1'b1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.ctrl = 4'($urandom);
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
   endtask

   task automatic wait_out(input string nm);
      int k = 0;
      @(negedge clk);
      while (!bus.out_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_out_valid"}, bus.out_valid, 1'b1);
   endtask

   localparam int NT = 22;
   logic [3:0]   t_op [NT] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL,
                               OP_SHL, OP_SHL, OP_SHR, OP_SHR, OP_SRA, OP_SRA, OP_MUL, OP_DIV,
                               OP_MOD, OP_MOD, 4'd12, 4'd15, OP_DIV, OP_MUL};
   logic [W-1:0] t_a  [NT] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'hF0F0, 16'hF0F0, 16'hFFFF, 16'h8001,
                               16'h1234, 16'h0001, 16'h0003, 16'h8000, 16'h8000, 16'h8001, 16'h1234, 16'hFFFF,
                               16'd100,  16'd5,    16'h1234, 16'hFFFF, 16'd3,    16'h0000};
   logic [W-1:0] t_b  [NT] = '{16'h0001, 16'h0001, 16'h0001, 16'h0005, 16'h0FF0, 16'h0F0F, 16'hFFFF, 16'h0001,
                               16'h0000, 16'h0013, 16'h0001, 16'h000F, 16'h0004, 16'h000F, 16'h5678, 16'h0001,
                               16'd7,    16'd0,    16'h5678, 16'h0001, 16'd10,   16'hBEEF};

   initial begin
      exp_t e;
      bus.in_valid = 1'b0;
      bus.ctrl = '0;
      bus.a = '0;
      bus.b = '0;
      bus.out_ready = 1'b1;

      e = model(OP_SRA, 16'h8000, 16'h0004);
      chk("model_sra", e.y, 16'hF800);
      e = model(OP_SHL, 16'h8001, 16'h0001);
      chk("model_shl_flags", {e.y, 11'd0, e.f}, {16'h0002, 11'd0, 5'b00100});
      e = model(OP_MOD, 16'd100, 16'd7);
      chk("model_mod", {e.y, e.hi}, {16'd2, 16'd14});

      repeat (3) @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_y", {bus.y, bus.y_hi}, 32'h0);
      chk("rst_flags", bus.flags, 5'b0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;

      send(OP_ADD, 16'h00F0, 16'h000F);
      @(negedge clk);
      chk("add_valid", bus.out_valid, 1'b1);
      chk("add_y", bus.y, 16'h00FF);
      chk("add_flags", bus.flags, 5'b00000);
      @(posedge clk); #1;
      send(OP_SUB, 16'h0100, 16'h000F);
      @(negedge clk);
      chk("sub_y", bus.y, 16'h00F1);
      chk("sub_flags", bus.flags, 5'b00000);
      @(posedge clk); #1;

      send(OP_MUL, 16'h0003, 16'h0004);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("mul_busy_in_ready", {bus.in_ready, bus.out_valid}, 2'b00);
      end
      @(negedge clk);
      chk("mul_valid_c17", bus.out_valid, 1'b1);
      chk("mul_y", {bus.y, bus.y_hi}, {16'h000C, 16'h0000});
      @(posedge clk); #1;
      send(OP_MUL, 16'hFFFF, 16'hFFFF);
      wait_out("mul_ff");
      chk("mul_ff_y", {bus.y, bus.y_hi}, {16'h0001, 16'hFFFE});
      chk("mul_ff_flags", bus.flags, 5'b01100);
      @(posedge clk); #1;

      send(OP_NEG, 16'h0003, 16'h0000);
      @(negedge clk);
      chk("neg3", {11'd0, bus.flags, bus.y}, {11'd0, 5'b00110, 16'hFFFD});
      @(posedge clk); #1;
      send(OP_NEG, 16'h8000, 16'h0000);
      @(negedge clk);
      chk("neg_min", {11'd0, bus.flags, bus.y}, {11'd0, 5'b01110, 16'h8000});
      @(posedge clk); #1;

      send(OP_DIV, 16'd100, 16'd7);
      wait_out("div");
      chk("div_y", {bus.y, bus.y_hi}, {16'd14, 16'd2});
      @(posedge clk); #1;
      send(OP_DIV, 16'd5, 16'd0);
      @(negedge clk);
      chk("div0_valid", bus.out_valid, 1'b1);
      chk("div0_y", {bus.y, bus.y_hi}, {16'hFFFF, 16'h0005});
      chk("div0_flags", bus.flags, 5'b10010);

      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      send(OP_ADD, 16'h0001, 16'h0002);
      bus.in_valid = 1'b1;
      bus.ctrl = OP_XOR;
      bus.a = 16'h00FF;
      bus.b = 16'h0F0F;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_hold", {bus.in_ready, bus.out_valid, bus.y}, {1'b0, 1'b1, 16'h0003});
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("bp_second", {bus.out_valid, bus.y}, {1'b1, 16'h0FF0});
      @(posedge clk); #1;

      send(OP_MUL, 16'h1111, 16'h0003);
      repeat (7) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("midrst_valid", bus.out_valid, 1'b0);
      @(posedge clk); #1 reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("midrst_no_stale", {bus.out_valid, bus.in_ready}, 2'b01);
      end
      @(posedge clk); #1;
      send(OP_ADD, 16'h0001, 16'h0001);
      @(negedge clk);
      chk("post_rst_add", {bus.out_valid, bus.y}, {1'b1, 16'h0002});
      @(posedge clk); #1;

      for (int i = 0; i < NT; i++) send(t_op[i], t_a[i], t_b[i]);
      for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
      chk("drain", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU, the successor to the single-cycle 16-bit datapath ALU. Adds valid/ready handshakes on operand and result sides, status flags, and iterative multiply/divide with full double-width results. Sits between register-read and writeback in the CPU datapath, with a one-entry result register.

Parameters:
WIDTH, 16, operand/result width in bits (>= 4)
CTRL_W, 4, opcode width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operands and opcode valid
in_ready  out  1  ALU accepts an operation this cycle
ctrl  in  CTRL_W  opcode
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result register holds a valid result
out_ready  in  1  consumer takes the result
y  out  WIDTH  primary result
y_hi  out  WIDTH  MUL high half / DIV-MOD remainder, else 0
flags  out  5  {dz, v, c, n, z}

Behaviour:
- Reset asserted at any time forces state IDLE; out_valid=0, y=0, y_hi=0, flags=0, and all iteration counters/shift registers are cleared. Any in-flight operation is discarded.
- Opcodes: ADD=0, SUB=1, MUL=2, NEG=3, AND=4, OR=5, XOR=6, SHL=7, SHR=8, SRA=9, DIV=10, MOD=11. Codes 12-15 give y=0 and y_hi=0, with the z flag set and all other flags 0.
- Accept happens when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready), so back-to-back single-cycle ops sustain one op per cycle under out_ready=1.
- Single-cycle ops (all except MUL/DIV/MOD): result is registered on the accept edge, so out_valid is high the next cycle (latency 1).
- ADD/SUB: y = a±b mod 2^WIDTH.
  - c: carry out for ADD; borrow (a<b unsigned) for SUB.
  - v: signed overflow.
- NEG: y = 0-a; c = (a!=0); v = (a==100..0).
- Logic ops: c=0, v=0.
- Shifts: shift amount = b[$clog2(WIDTH)-1:0]; higher bits of b are ignored.
  - SHL/SHR: c = last bit shifted out, 0 if amount 0.
  - SRA: sign-fills.
- MUL: unsigned shift-add, one bit per cycle; state MUL for WIDTH cycles. {y_hi,y} = a*b. out_valid rises WIDTH+1 cycles after accept. c = v = (y_hi!=0).
- DIV/MOD: unsigned restoring division, state DIV for WIDTH cycles; latency WIDTH+1.
  - DIV: y=quotient, y_hi=remainder.
  - MOD: y=remainder, y_hi=quotient.
  - If b==0: skip iteration; result is registered with latency 1; y=all-ones, y_hi=a, dz=1.
- n = y[WIDTH-1]; z = (y==0), for all ops.
- dz is 0 for all ops except DIV/MOD by zero.
- States: IDLE, MUL, DIV.
  - IDLE→MUL/DIV on accept of MUL, or DIV/MOD with b!=0.
  - MUL/DIV→IDLE when the iteration counter reaches WIDTH-1; the result is written to the output register on that edge.
- Output register holds y/y_hi/flags stable while out_valid && !out_ready.
- out_valid clears on out_ready unless a new result is written in the same cycle.
- Operands are captured on accept; a/b/ctrl changes during MUL/DIV have no effect.
- in_valid while in_ready=0 is ignored; the upstream holds the operation until it is accepted.

Test Plan:
- Reset low, out_ready=1; ADD a=0x00F0 b=0x000F -> next cycle out_valid=1, y=0x00FF, flags=0. Then SUB a=0x0100 b=0x000F on the following cycle -> y=0x00F1, c=0.
- MUL a=0x0003 b=0x0004 -> in_ready=0 for 16 cycles; out_valid at cycle 17; y=0x000C, y_hi=0. MUL 0xFFFF*0xFFFF -> y=0x0001, y_hi=0xFFFE, c=v=1.
- NEG a=0x0003 -> y=0xFFFD, n=1, c=1; NEG a=0x8000 -> y=0x8000, v=1.
- DIV a=100 b=7 -> after 17 cycles y=14, y_hi=2. DIV a=5 b=0 -> latency 1, y=0xFFFF, y_hi=5, dz=1.
- Backpressure: out_ready=0 after an ADD -> y held, in_ready=0 for multiple cycles; in_valid held with a second op -> accepted only in the cycle out_ready returns to 1.
- Assert reset at cycle 8 of a MUL -> out_valid=0, in_ready=1 after release, no stale result; a subsequent ADD 1+1 gives y=2.
